// File: rtl/eth_ingress_pkt_fifo.sv
// Store-and-forward ingress packet buffer feeding one eth_sw input port.
// Only complete packets are committed; aborted, truncated-by-overflow and oversized packets are dropped.
module eth_ingress_pkt_fifo #(
  parameter int DEPTH = 64,
  parameter int CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   resetN,
  input  logic                   srcValid,
  input  logic [31:0]            srcData,
  input  logic                   srcSop,
  input  logic                   srcEop,
  input  logic                   portStall,
  output logic [31:0]            outData,
  output logic                   outSop,
  output logic                   outEop,
  output logic [$clog2(DEPTH):0] fifoLevel,
  output logic [CNT_W-1:0]       pktInCnt,
  output logic [CNT_W-1:0]       pktOutCnt,
  output logic [CNT_W-1:0]       pktDropCnt
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  typedef enum logic [1:0] {W_IDLE, W_PKT, W_DROP} wstate_t;
  typedef enum logic {R_IDLE, R_SEND} rstate_t;

  logic [33:0]   mem [DEPTH];
  logic [33:0]   rd_word;
  logic [PW-1:0] wrPtr, rdPtr, cmtPtr, cmtPkts;
  logic [PW-1:0] wr_ptr_next, cmt_ptr_next, rd_ptr_next, base;
  wstate_t       wstate, wstate_next;
  rstate_t       rstate, rstate_next;
  logic          wr_en, start_pkt, commit, launch;
  logic [1:0]    drop_inc;
  logic [31:0]   out_data_next;
  logic          out_sop_next, out_eop_next;
  logic [CNT_W:0] drop_sum;

  assign rd_word   = mem[rdPtr[AW-1:0]];
  assign fifoLevel = wrPtr - rdPtr;
  assign drop_sum  = {1'b0, pktDropCnt} + {{(CNT_W-1){1'b0}}, drop_inc};

  // A sop always restarts from cmtPtr; in idle/drop wrPtr already equals cmtPtr.
  always_comb begin
    wstate_next  = wstate;
    wr_ptr_next  = wrPtr;
    cmt_ptr_next = cmtPtr;
    base         = wrPtr;
    wr_en        = 1'b0;
    start_pkt    = 1'b0;
    commit       = 1'b0;
    drop_inc     = 2'd0;
    if (srcValid) begin
      case (wstate)
        W_PKT: begin
          if (srcSop) begin
            drop_inc    = 2'd1;
            base        = cmtPtr;
            wr_ptr_next = cmtPtr;
            start_pkt   = 1'b1;
          end else if ((wrPtr - rdPtr) == PW'(DEPTH)) begin
            drop_inc    = 2'd1;
            wr_ptr_next = cmtPtr;
            wstate_next = srcEop ? W_IDLE : W_DROP;
          end else begin
            wr_en       = 1'b1;
            wr_ptr_next = wrPtr + PW'(1);
            if (srcEop) begin
              commit       = 1'b1;
              cmt_ptr_next = wrPtr + PW'(1);
              wstate_next  = W_IDLE;
            end
          end
        end
        default: begin
          if (srcSop) begin
            start_pkt = 1'b1;
          end else if (wstate == W_DROP && srcEop) begin
            wstate_next = W_IDLE;
          end
        end
      endcase
      if (start_pkt) begin
        if ((base - rdPtr) == PW'(DEPTH)) begin
          drop_inc    = drop_inc + 2'd1;
          wr_ptr_next = base;
          wstate_next = srcEop ? W_IDLE : W_DROP;
        end else begin
          wr_en       = 1'b1;
          wr_ptr_next = base + PW'(1);
          if (srcEop) begin
            commit       = 1'b1;
            cmt_ptr_next = base + PW'(1);
            wstate_next  = W_IDLE;
          end else begin
            wstate_next = W_PKT;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      wstate <= W_IDLE;
      wrPtr  <= '0;
      cmtPtr <= '0;
    end else begin
      wstate <= wstate_next;
      wrPtr  <= wr_ptr_next;
      cmtPtr <= cmt_ptr_next;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[base[AW-1:0]] <= {start_pkt, srcEop, srcData};
  end

  // Staying in R_SEND for the cycle after eop produces the mandatory idle gap.
  always_comb begin
    rstate_next   = rstate;
    rd_ptr_next   = rdPtr;
    launch        = 1'b0;
    out_data_next = '0;
    out_sop_next  = 1'b0;
    out_eop_next  = 1'b0;
    case (rstate)
      R_IDLE: begin
        if (cmtPkts != '0 && !portStall) begin
          launch        = 1'b1;
          rd_ptr_next   = rdPtr + PW'(1);
          out_data_next = rd_word[31:0];
          out_sop_next  = rd_word[33];
          out_eop_next  = rd_word[32];
          rstate_next   = R_SEND;
        end
      end
      R_SEND: begin
        if (outEop) begin
          rstate_next = R_IDLE;
        end else begin
          rd_ptr_next   = rdPtr + PW'(1);
          out_data_next = rd_word[31:0];
          out_eop_next  = rd_word[32];
        end
      end
      default: rstate_next = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      rstate  <= R_IDLE;
      rdPtr   <= '0;
      outData <= '0;
      outSop  <= 1'b0;
      outEop  <= 1'b0;
    end else begin
      rstate  <= rstate_next;
      rdPtr   <= rd_ptr_next;
      outData <= out_data_next;
      outSop  <= out_sop_next;
      outEop  <= out_eop_next;
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      cmtPkts    <= '0;
      pktInCnt   <= '0;
      pktOutCnt  <= '0;
      pktDropCnt <= '0;
    end else begin
      cmtPkts <= cmtPkts + PW'(commit) - PW'(launch);
      if (commit && pktInCnt != '1) pktInCnt <= pktInCnt + CNT_W'(1);
      if (out_eop_next && pktOutCnt != '1) pktOutCnt <= pktOutCnt + CNT_W'(1);
      pktDropCnt <= drop_sum[CNT_W] ? '1 : drop_sum[CNT_W-1:0];
    end
  end

endmodule

// File: tb/tb_eth_ingress_pkt_fifo.sv
// Bench for eth_ingress_pkt_fifo: queue-based packet model checked every cycle,
// plus directed timing scenarios with hand-computed expectations.
module tb_eth_ingress_pkt_fifo;
  localparam int DEPTH = 8;
  localparam int CNT_W = 16;

  logic                   clk = 1'b0;
  logic                   resetN;
  logic                   srcValid, srcSop, srcEop, portStall;
  logic [31:0]            srcData;
  logic [31:0]            outData;
  logic                   outSop, outEop;
  logic [$clog2(DEPTH):0] fifoLevel;
  logic [CNT_W-1:0]       pktInCnt, pktOutCnt, pktDropCnt;

  eth_ingress_pkt_fifo #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .resetN(resetN), .srcValid(srcValid), .srcData(srcData),
    .srcSop(srcSop), .srcEop(srcEop), .portStall(portStall),
    .outData(outData), .outSop(outSop), .outEop(outEop), .fifoLevel(fifoLevel),
    .pktInCnt(pktInCnt), .pktOutCnt(pktOutCnt), .pktDropCnt(pktDropCnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {logic sop; logic eop; logic [31:0] data;} word_t;
  typedef enum {M_IDLE, M_PKT, M_DROP} mmode_t;

  word_t  expq[$];
  word_t  staging[$];
  mmode_t mode     = M_IDLE;
  int     rd_idx   = 0;
  int     exp_in   = 0;
  int     exp_drop = 0;
  int     exp_out  = 0;
  int     checks   = 0;
  int     errors   = 0;

  function automatic logic [33:0] ow(logic s, logic e, logic [31:0] d);
    return {s, e, d};
  endfunction

  function automatic int stored();
    return expq.size() - rd_idx + staging.size();
  endfunction

  task automatic check(input string name, input logic [33:0] actual, input logic [33:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: actual=0x%0h required=0x%0h at t=%0t", name, actual, expected, $time);
    end
  endtask

  function automatic void model_commit();
    foreach (staging[i]) expq.push_back(staging[i]);
    staging.delete();
    exp_in++;
    mode = M_IDLE;
  endfunction

  // Packet-level model: staging holds the open packet, expq every committed word in order.
  initial forever begin
    @(posedge clk or negedge resetN);
    if (!resetN) begin
      expq.delete();
      staging.delete();
      mode     = M_IDLE;
      exp_in   = 0;
      exp_drop = 0;
    end else if (srcValid) begin
      if (srcSop) begin
        if (mode == M_PKT) begin
          exp_drop++;
          staging.delete();
        end
        if (stored() == DEPTH) begin
          exp_drop++;
          mode = srcEop ? M_IDLE : M_DROP;
        end else begin
          staging.push_back({1'b1, srcEop, srcData});
          if (srcEop) model_commit();
          else mode = M_PKT;
        end
      end else if (mode == M_PKT) begin
        if (stored() == DEPTH) begin
          exp_drop++;
          staging.delete();
          mode = srcEop ? M_IDLE : M_DROP;
        end else begin
          staging.push_back({1'b0, srcEop, srcData});
          if (srcEop) model_commit();
        end
      end else if (mode == M_DROP && srcEop) begin
        mode = M_IDLE;
      end
    end
  end

  task automatic compare_loop();
    logic in_pkt = 1'b0;
    logic prev_eop = 1'b0;
    forever begin
      @(negedge clk);
      if (!resetN) begin
        rd_idx   = 0;
        exp_out  = 0;
        in_pkt   = 1'b0;
        prev_eop = 1'b0;
        check("rst_out", {outSop, outEop, outData}, 34'd0);
        check("rst_level", 34'(fifoLevel), 34'd0);
        check("rst_cnts", {2'b00, pktInCnt, pktOutCnt}, 34'd0);
        check("rst_drop", 34'(pktDropCnt), 34'd0);
      end else begin
        if (outSop || in_pkt) begin
          if (outSop) check("gap", 34'(prev_eop), 34'd0);
          if (rd_idx >= expq.size()) begin
            check("unexpected_word", {outSop, outEop, outData}, 34'd0);
          end else begin
            check("out_word", {outSop, outEop, outData}, expq[rd_idx]);
            rd_idx++;
          end
          in_pkt = !outEop;
          if (outEop) exp_out++;
        end else begin
          check("idle_out", {outSop, outEop, outData}, 34'd0);
        end
        prev_eop = outEop;
        check("level", 34'(fifoLevel), 34'(stored()));
        check("in_cnt", 34'(pktInCnt), 34'(exp_in));
        check("out_cnt", 34'(pktOutCnt), 34'(exp_out));
        check("drop_cnt", 34'(pktDropCnt), 34'(exp_drop));
      end
    end
  endtask

  task automatic drive(input logic [31:0] d, input logic s, input logic e);
    srcValid = 1'b1;
    srcData  = d;
    srcSop   = s;
    srcEop   = e;
  endtask

  task automatic idle_in();
    srcValid = 1'b0;
    srcData  = '0;
    srcSop   = 1'b0;
    srcEop   = 1'b0;
  endtask

  task automatic send_pkt(input logic [31:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      drive(base + 32'(i), i == 0, i == n - 1);
    end
    @(negedge clk);
    idle_in();
  endtask

  task automatic out_at_edge(input string name, input logic [33:0] expected);
    @(posedge clk);
    #1;
    check(name, {outSop, outEop, outData}, expected);
  endtask

  initial begin
    logic found;
    resetN    = 1'b1;
    portStall = 1'b0;
    idle_in();
    #1 resetN = 1'b0;
    fork
      compare_loop();
    join_none
    repeat (2) @(negedge clk);
    check("reset_out", {outSop, outEop, outData}, 34'd0);
    check("reset_level", 34'(fifoLevel), 34'd0);
    #3 resetN = 1'b1;
    repeat (2) @(negedge clk);

    $display("[TB] basic forward");
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      drive(32'h11 * (i + 1), i == 0, i == 3);
    end
    @(posedge clk);
    #1 idle_in();
    out_at_edge("t1_w0", ow(1'b1, 1'b0, 32'h11));
    check("t1_level", 34'(fifoLevel), 34'd3);
    out_at_edge("t1_w1", ow(1'b0, 1'b0, 32'h22));
    out_at_edge("t1_w2", ow(1'b0, 1'b0, 32'h33));
    out_at_edge("t1_w3", ow(1'b0, 1'b1, 32'h44));
    check("t1_outcnt", 34'(pktOutCnt), 34'd1);
    check("t1_incnt", 34'(pktInCnt), 34'd1);
    out_at_edge("t1_gap", 34'd0);
    check("t1_level_end", 34'(fifoLevel), 34'd0);
    repeat (2) @(negedge clk);

    $display("[TB] single word and back-to-back");
    @(negedge clk) drive(32'hA5, 1'b1, 1'b1);
    @(negedge clk) drive(32'hB1, 1'b1, 1'b0);
    @(posedge clk) #1 check("t2_single", {outSop, outEop, outData}, ow(1'b1, 1'b1, 32'hA5));
    @(negedge clk) drive(32'hB2, 1'b0, 1'b1);
    @(posedge clk) #1 check("t2_gap", {outSop, outEop, outData}, 34'd0);
    @(negedge clk) idle_in();
    out_at_edge("t2_b1", ow(1'b1, 1'b0, 32'hB1));
    out_at_edge("t2_b2", ow(1'b0, 1'b1, 32'hB2));
    repeat (3) @(negedge clk);

    $display("[TB] stall at boundary");
    @(negedge clk) portStall = 1'b1;
    send_pkt(32'hC1, 3);
    for (int i = 0; i < 10; i++) out_at_edge("t3_stalled", 34'd0);
    @(negedge clk) portStall = 1'b0;
    out_at_edge("t3_launch", ow(1'b1, 1'b0, 32'hC1));
    @(negedge clk) portStall = 1'b1;
    out_at_edge("t3_mid", ow(1'b0, 1'b0, 32'hC2));
    out_at_edge("t3_last", ow(1'b0, 1'b1, 32'hC3));
    @(negedge clk) portStall = 1'b0;
    repeat (3) @(negedge clk);

    $display("[TB] overflow");
    send_pkt(32'hD0, 10);
    check("t4_level_between", 34'(fifoLevel), 34'd0);
    check("t4_drop", 34'(pktDropCnt), 34'd1);
    send_pkt(32'hE0, 3);
    repeat (8) @(negedge clk);
    check("t4_incnt", 34'(pktInCnt), 34'd5);
    check("t4_outcnt", 34'(pktOutCnt), 34'd5);

    $display("[TB] abort and stray");
    @(negedge clk) drive(32'hF0, 1'b0, 1'b0);
    @(negedge clk) drive(32'hF1, 1'b1, 1'b0);
    @(negedge clk) drive(32'hF2, 1'b0, 1'b0);
    @(negedge clk) drive(32'hF3, 1'b0, 1'b0);
    send_pkt(32'h61, 3);
    repeat (8) @(negedge clk);
    check("t5_drop", 34'(pktDropCnt), 34'd2);
    check("t5_incnt", 34'(pktInCnt), 34'd6);
    check("t5_outcnt", 34'(pktOutCnt), 34'd6);
    check("t5_drained", 34'(rd_idx), 34'(expq.size()));

    $display("[TB] reset mid-output");
    send_pkt(32'h71, 5);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(posedge clk);
      #1;
      if (outSop) found = 1'b1;
    end
    check("t6_launch_seen", 34'(found), 34'd1);
    out_at_edge("t6_second", ow(1'b0, 1'b0, 32'h72));
    #2 resetN = 1'b0;
    #1;
    check("t6_out_zero", {outSop, outEop, outData}, 34'd0);
    check("t6_level_zero", 34'(fifoLevel), 34'd0);
    check("t6_cnt_zero", {2'b00, pktInCnt, pktOutCnt}, 34'd0);
    @(negedge clk);
    #3 resetN = 1'b1;
    for (int i = 0; i < 10; i++) out_at_edge("t6_residual", 34'd0);
    check("t6_level_after", 34'(fifoLevel), 34'd0);

    send_pkt(32'h81, 2);
    repeat (6) @(negedge clk);
    check("post_incnt", 34'(pktInCnt), 34'd1);
    check("post_outcnt", 34'(pktOutCnt), 34'd1);
    check("post_drained", 34'(rd_idx), 34'(expq.size()));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
